mac_pipe_datapath: RTL
======================

# mac_pipe_datapath

Two-stage signed multiply-accumulate datapath driven by the pipeline controller's `ld_mult`, `ld_add`, `pipe_stall` and `inner_rst` outputs. It sits directly downstream of that controller. It feeds the controller's `can_mult` input from upstream operand availability. Stage M registers one product per load; stage A folds products into an accumulator and emits one result every N products.

## Interface
- `DW`, 8, operand width, two's-complement signed.
- `AW`, 20, accumulator/result width; must satisfy AW ≥ 2·DW.
- `N`, 4, products per result; N ≥ 1.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `inner_rst` input 1: synchronous clear of the pipeline (same signal the controller uses).
- `in_valid` input 1: upstream operand pair `a`/`b` is present.
- `a` input DW: signed multiplicand.
- `b` input DW: signed multiplier.
- `in_ready` output 1: operand pair consumed this cycle.
- `can_mult` output 1: to controller; operand available for stage M.
- `ld_mult` input 1: advance stage M.
- `ld_add` input 1: advance stage A.
- `pipe_stall` input 1: freeze all pipeline registers.
- `result` output AW: last completed accumulation.
- `out_valid` output 1: one-cycle pulse, `result` updated.
- `busy` output 1: product in flight or partial sum nonzero-count.

## Operation
- Registers:
  - `prod_r` [2·DW] and `prod_v` in stage M.
  - `acc` [AW] and `cnt` [⌈log2 N⌉+1] in stage A.
  - `result` [AW] and `out_valid`.
- Combinational outputs:
  - `can_mult` = `in_valid`.
  - `in_ready` = `in_valid` & `ld_mult` & ~`pipe_stall` & ~`inner_rst`.
  - `busy` = `prod_v` | (`cnt` ≠ 0).
- Priority per edge: `rst` (async) > `inner_rst` > `pipe_stall` > normal update.
- Stage M, when `ld_mult` is high:
  - `prod_r` ← signed `a`·`b` (full 2·DW).
  - `prod_v` ← `in_valid`. A missing operand inserts a bubble.
  - When `ld_mult` is low, `prod_r` and `prod_v` hold.
- Stage A, when `ld_add` and `prod_v` are high:
  - sum = `acc` + sign-extend(`prod_r`) to AW, modulo 2^AW (wrap, no saturation).
  - If `cnt` = N−1: `result` ← sum, `out_valid` ← 1, `acc` ← 0, `cnt` ← 0.
  - Otherwise: `acc` ← sum, `cnt` ← `cnt`+1.
- Stage A no-ops: `ld_add` with `prod_v`=0 does nothing. `ld_add`=0 holds stage A.
- Simultaneous `ld_mult` & `ld_add`: stage A consumes the old `prod_r`, and stage M loads the new one in the same edge. There is no forwarding, and no product is lost or doubled.
- `out_valid` is 0 on every edge that does not complete a group.
- `pipe_stall`=1:
  - No register changes, except `out_valid` clears to 0.
  - `in_ready`=0.
- `inner_rst`=1:
  - `prod_v`, `acc`, `cnt`, `out_valid` clear.
  - `result` and `prod_r` hold.
  - The partial group is discarded.
- Async `rst`: all registers cleared, including `result` and `prod_r`.

## Timing
- Reset values: `result`=0, `out_valid`=0, `busy`=0. `in_ready` and `can_mult` follow `in_valid`, gated as above.
- Operand accepted at edge k (`in_ready` high in the preceding cycle) is in `prod_r` after edge k.
- That product is accumulated at the first later edge with `ld_add`=1 and no stall. With the controller's PIPE state (`ld_mult`=`ld_add`=1 every cycle), this is edge k+1.
- Steady-state PIPE:
  - First `out_valid` pulse after edge k0+N, where k0 is the first accepting edge.
  - Then one pulse every N cycles.
- Throughput is one operand pair per cycle.
- `rst` asserted mid-group: outputs go to reset values immediately (asynchronously), with no pulse.
- `inner_rst` coincident with the group's final add: clear wins, no `out_valid`, `result` unchanged.

## Test plan
- Reset then PIPE, N=4, pairs (1,2),(3,4),(−5,6),(7,−8) on consecutive cycles -> single `out_valid` pulse 4 cycles after first accept, `result`=2+12−30−56=−72 (20-bit two's complement 0xFFFB8), `busy`=0 next cycle.
- Extremes DW=8: four pairs of (−128,−128) -> `result`=65536 (0x10000). Then four pairs of (127,−128) -> `result`=−65024, no overflow at AW=20.
- Bubble: `in_valid` low for 2 cycles mid-group with `ld_mult`/`ld_add` high -> `in_ready` low in those cycles, `cnt` holds, `out_valid` delayed by exactly 2 cycles, same sum.
- Stall: `pipe_stall` high 3 cycles after the 2nd accept -> `prod_r`, `acc`, `cnt` frozen, `in_ready`=0, result correct and delayed 3 cycles.
- `inner_rst` after 3 of 4 adds, then 4 fresh pairs of (1,1) -> `result`=4, not including the discarded partial sum. A prior `result` holds until then.
- Async `rst` asserted between edges mid-group -> `result`=0, `out_valid`=0, `busy`=0 before the next edge.

Source files
------------

// File: rtl/mac_pipe_datapath_if.sv
// ============================================================================
// Module      : mac_pipe_datapath_if
// Description : Operand and controller handshake bundle for the MAC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_pipe_datapath_if #(
  parameter int DW = 8,
  parameter int AW = 20
);
  logic          in_valid;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          in_ready;
  logic          can_mult;
  logic          ld_mult;
  logic          ld_add;
  logic          pipe_stall;
  logic          inner_rst;
  logic [AW-1:0] result;
  logic          out_valid;
  logic          busy;

  modport master (
    output in_valid, a, b, ld_mult, ld_add, pipe_stall, inner_rst,
    input  in_ready, can_mult, result, out_valid, busy
  );

  modport slave (
    input  in_valid, a, b, ld_mult, ld_add, pipe_stall, inner_rst,
    output in_ready, can_mult, result, out_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/mac_pipe_datapath.sv
// ============================================================================
// Module      : mac_pipe_datapath
// Description : Two-stage signed multiply-accumulate; one result per N products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_pipe_datapath #(
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int N  = 4
) (
  input  wire                  clk,
  input  wire                  rst,
  mac_pipe_datapath_if.slave   bus
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] c_last = CW'(N - 1);

  if (AW < 2 * DW) begin : g_bad_aw
    $error("mac_pipe_datapath: AW must be at least 2*DW");
  end

  logic [2*DW-1:0] r_prod;
  logic            r_prod_v;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_result;
  logic            r_out_valid;

  logic [2*DW-1:0] w_prod;
  logic [AW-1:0]   w_ext;
  logic [AW-1:0]   w_sum;
  logic            w_add;

  // Operands are widened before multiplying so the full 2*DW product is exact.
  assign w_prod = $signed({{DW{bus.a[DW-1]}}, bus.a}) * $signed({{DW{bus.b[DW-1]}}, bus.b});
  assign w_ext  = AW'($signed(r_prod));
  assign w_sum  = r_acc + w_ext;
  assign w_add  = bus.ld_add & r_prod_v;

  assign bus.can_mult  = bus.in_valid;
  assign bus.in_ready  = bus.in_valid & bus.ld_mult & ~bus.pipe_stall & ~bus.inner_rst;
  assign bus.busy      = r_prod_v | (r_cnt != '0);
  assign bus.result    = r_result;
  assign bus.out_valid = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod      <= '0;
      r_prod_v    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.inner_rst) begin
      r_prod_v    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.pipe_stall) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      // Stage A reads the old product while stage M overwrites it on the same edge.
      if (bus.ld_mult) begin
        r_prod   <= w_prod;
        r_prod_v <= bus.in_valid;
      end
      if (w_add) begin
        if (r_cnt == c_last) begin
          r_result    <= w_sum;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
